time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Consumes the 1-cycle tick pulses produced by the clock divider and keeps time of day as BCD HH:MM:SS.
- Provides a two-button set-mode state machine (mode / increment) with auto-repeat on held increment.
- Sits between the tick generator and the 7-segment display driver; all logic runs on the fast system clock, with tick used as an enable.

Parameters:
- HOUR_MAX, 23, last hour value before wrap to 00 (legal: 23 or 11).
- REPEAT_DELAY, 2, ticks btn_inc must be held in a set state before auto-repeat starts; 0 disables auto-repeat.

Ports:
- clk_in  input  1  system clock, all logic on posedge.
- reset_  input  1  asynchronous active-low reset.
- tick  input  1  one-clk_in-cycle enable pulse, nominal 1 Hz.
- btn_mode  input  1  debounced, synchronous level; rising edge detected internally.
- btn_inc  input  1  debounced, synchronous level; rising edge detected internally.
- hh_tens  output  2  BCD hours tens.
- hh_ones  output  4  BCD hours ones.
- mm_tens  output  3  BCD minutes tens.
- mm_ones  output  4  BCD minutes ones.
- ss_tens  output  3  BCD seconds tens.
- ss_ones  output  4  BCD seconds ones.
- set_mode  output  2  0 = RUN, 1 = SET_HH, 2 = SET_MM (3 never driven).
- day_wrap  output  1  one-cycle pulse on rollover to 00:00:00.

Behaviour:
- Reset (async, reset_ = 0):
  - All digits 0; state RUN; day_wrap 0.
  - Edge-detect history regs 0; hold_cnt 0.
  - All outputs are registered.
- Edge detect: an edge fires when the level is 1 and the registered previous level is 0. A button held high through reset release produces no edge.
- State machine:
  - RUN -> SET_HH -> SET_MM -> RUN, advancing on each btn_mode edge.
  - On the edge into SET_HH, seconds are cleared to 00.
  - Time is frozen in SET_HH and SET_MM: ticks do not advance it.
- RUN state, on tick:
  - ss +1.
  - 59 -> 00 with carry into mm.
  - mm 59 -> 00 with carry into hh.
  - hh HOUR_MAX -> 00 with day_wrap = 1 for exactly one clk_in cycle.
  - Digits update on the clock edge after the tick cycle (1-cycle latency). day_wrap asserts in the same cycle the digits first show 00:00:00.
- SET_HH, on btn_inc edge: hh +1, HOUR_MAX -> 00; no carry and no day_wrap.
- SET_MM, on btn_inc edge: mm +1, 59 -> 00; no carry into hh.
- btn_inc in RUN is ignored.
- Auto-repeat (set states, REPEAT_DELAY > 0):
  - hold_cnt clears when btn_inc = 0 or on any btn_mode edge.
  - On tick with btn_inc = 1: if hold_cnt < REPEAT_DELAY, hold_cnt +1; otherwise increment the current field, same as an edge.
  - An edge and a repeat-tick in the same cycle produce a single increment.
  - hold_cnt saturates and does not wrap.
- Priority within one cycle:
  1. btn_mode edge.
  2. btn_inc edge or repeat.
  3. tick.
  - A tick coinciding with a btn_mode edge is discarded, including in RUN.
  - A btn_inc edge coinciding with a btn_mode edge is discarded.
- BCD invariant: digits never hold illegal codes. hh never exceeds HOUR_MAX; mm and ss never exceed 59.
- Reset mid-operation, including mid-set or during a day_wrap cycle, returns immediately to 00:00:00 RUN with day_wrap 0.
- HOUR_MAX = 11: hours count 00..11, and 11:59:59 -> 00:00:00 raises day_wrap.

Test Plan:
- Reset, then 3661 ticks in RUN -> display 01:01:01; day_wrap never asserted; set_mode = 0.
- Preload via set mode to 23:59:00, then 60 ticks -> 00:00:00 on the final tick's following cycle; day_wrap high exactly 1 cycle, coincident with the 00:00:00 digits.
- From 10:20:35: btn_mode edge -> set_mode = 1, ss = 00. Then 14 btn_inc edges -> hh = 00. Then btn_mode edge and 45 btn_inc edges -> mm = 05, hh unchanged at 00. Then btn_mode edge -> RUN. Ticks in set states leave the display frozen.
- SET_MM at mm = 58 with btn_inc held high, REPEAT_DELAY = 2, and 5 ticks -> initial edge gives 59, ticks 1-2 no change, ticks 3-5 give 00, 01, 02.
- tick and btn_mode edge in the same cycle while in RUN at 12:00:10 -> state SET_HH, ss = 00, no seconds increment. btn_inc edge coinciding with btn_mode edge -> no hour change.
- Assert reset_ low for 1 cycle asynchronously mid-SET_MM at 07:33 -> outputs 00:00:00, set_mode = 0 without waiting for a clock edge. btn_mode held high across reset release -> no state change until it toggles.

Source files
------------

// File: rtl/time_keeper.sv
// BCD HH:MM:SS time-of-day counter with a two-button set mode and auto-repeat on held increment.
// Digits, set_mode and day_wrap are registered and update on the edge that samples tick or a button edge.
module time_keeper #(
    parameter int HOUR_MAX     = 23,
    parameter int REPEAT_DELAY = 2
) (
    input  logic       clk_in,
    input  logic       reset_,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] hh_tens,
    output logic [3:0] hh_ones,
    output logic [2:0] mm_tens,
    output logic [3:0] mm_ones,
    output logic [2:0] ss_tens,
    output logic [3:0] ss_ones,
    output logic [1:0] set_mode,
    output logic       day_wrap
);

    localparam logic [1:0] HMAX_T = 2'(HOUR_MAX / 10);
    localparam logic [3:0] HMAX_O = 4'(HOUR_MAX % 10);
    localparam int         HW     = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam logic [HW-1:0] RD  = HW'(REPEAT_DELAY);
    localparam logic       REP_EN = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          mode_q, inc_q, armed;
    logic [HW-1:0] hold_cnt, hold_nxt;

    logic [1:0] hh_t_nxt;
    logic [3:0] hh_o_nxt;
    logic [2:0] mm_t_nxt;
    logic [3:0] mm_o_nxt;
    logic [2:0] ss_t_nxt;
    logic [3:0] ss_o_nxt;
    logic       day_wrap_nxt;

    logic mode_edge, inc_edge, in_set, hold_full, repeat_fire, bump;
    logic sec_last, min_last, hr_last;

    logic [1:0] hh_t_inc;
    logic [3:0] hh_o_inc;
    logic [2:0] mm_t_inc;
    logic [3:0] mm_o_inc;
    logic [2:0] ss_t_inc;
    logic [3:0] ss_o_inc;

    // armed stays low for the first clock after reset so a button held
    // through reset release is captured as history rather than seen as an edge
    assign mode_edge = armed & btn_mode & ~mode_q;
    assign inc_edge  = armed & btn_inc & ~inc_q;
    assign in_set    = (state != RUN);

    assign hold_full   = (hold_cnt >= RD);
    assign repeat_fire = REP_EN & in_set & tick & btn_inc & hold_full;
    assign bump        = in_set & ~mode_edge & (inc_edge | repeat_fire);

    assign sec_last = (ss_tens == 3'd5) && (ss_ones == 4'd9);
    assign min_last = (mm_tens == 3'd5) && (mm_ones == 4'd9);
    assign hr_last  = (hh_tens == HMAX_T) && (hh_ones == HMAX_O);

    assign ss_o_inc = (ss_ones == 4'd9) ? 4'd0 : ss_ones + 4'd1;
    assign ss_t_inc = sec_last ? 3'd0 : ((ss_ones == 4'd9) ? ss_tens + 3'd1 : ss_tens);
    assign mm_o_inc = (mm_ones == 4'd9) ? 4'd0 : mm_ones + 4'd1;
    assign mm_t_inc = min_last ? 3'd0 : ((mm_ones == 4'd9) ? mm_tens + 3'd1 : mm_tens);
    assign hh_o_inc = hr_last ? 4'd0 : ((hh_ones == 4'd9) ? 4'd0 : hh_ones + 4'd1);
    assign hh_t_inc = hr_last ? 2'd0 : ((hh_ones == 4'd9) ? hh_tens + 2'd1 : hh_tens);

    always_ff @(posedge clk_in or negedge reset_) begin
        if (!reset_) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            case (state)
                RUN:     state_nxt = SET_HH;
                SET_HH:  state_nxt = SET_MM;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        hh_t_nxt     = hh_tens;
        hh_o_nxt     = hh_ones;
        mm_t_nxt     = mm_tens;
        mm_o_nxt     = mm_ones;
        ss_t_nxt     = ss_tens;
        ss_o_nxt     = ss_ones;
        day_wrap_nxt = 1'b0;

        if (mode_edge) begin
            // entering SET_HH starts the new time on a whole minute
            if (state == RUN) begin
                ss_t_nxt = 3'd0;
                ss_o_nxt = 4'd0;
            end
        end else if (bump) begin
            if (state == SET_HH) begin
                hh_t_nxt = hh_t_inc;
                hh_o_nxt = hh_o_inc;
            end else begin
                mm_t_nxt = mm_t_inc;
                mm_o_nxt = mm_o_inc;
            end
        end else if ((state == RUN) && tick) begin
            ss_t_nxt = ss_t_inc;
            ss_o_nxt = ss_o_inc;
            if (sec_last) begin
                mm_t_nxt = mm_t_inc;
                mm_o_nxt = mm_o_inc;
                if (min_last) begin
                    hh_t_nxt     = hh_t_inc;
                    hh_o_nxt     = hh_o_inc;
                    day_wrap_nxt = hr_last;
                end
            end
        end
    end

    always_comb begin
        hold_nxt = hold_cnt;
        if (!btn_inc || mode_edge) begin
            hold_nxt = '0;
        end else if (REP_EN && in_set && tick && !hold_full) begin
            hold_nxt = hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset_) begin
        if (!reset_) begin
            hh_tens  <= 2'd0;
            hh_ones  <= 4'd0;
            mm_tens  <= 3'd0;
            mm_ones  <= 4'd0;
            ss_tens  <= 3'd0;
            ss_ones  <= 4'd0;
            day_wrap <= 1'b0;
            hold_cnt <= '0;
            mode_q   <= 1'b0;
            inc_q    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            hh_tens  <= hh_t_nxt;
            hh_ones  <= hh_o_nxt;
            mm_tens  <= mm_t_nxt;
            mm_ones  <= mm_o_nxt;
            ss_tens  <= ss_t_nxt;
            ss_ones  <= ss_o_nxt;
            day_wrap <= day_wrap_nxt;
            hold_cnt <= hold_nxt;
            mode_q   <= btn_mode;
            inc_q    <= btn_inc;
            armed    <= 1'b1;
        end
    end

    assign set_mode = state;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: time-of-day model in plain seconds arithmetic, checked every cycle plus directed literals.
module tb_time_keeper;

    localparam int HOUR_MAX     = 23;
    localparam int REPEAT_DELAY = 2;

    logic       clk_in   = 1'b0;
    logic       reset_   = 1'b1;
    logic       tick     = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [1:0] hh_tens;
    logic [3:0] hh_ones;
    logic [2:0] mm_tens;
    logic [3:0] mm_ones;
    logic [2:0] ss_tens;
    logic [3:0] ss_ones;
    logic [1:0] set_mode;
    logic       day_wrap;

    time_keeper #(.HOUR_MAX(HOUR_MAX), .REPEAT_DELAY(REPEAT_DELAY)) dut (
        .clk_in   (clk_in),
        .reset_   (reset_),
        .tick     (tick),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hh_tens  (hh_tens),
        .hh_ones  (hh_ones),
        .mm_tens  (mm_tens),
        .mm_ones  (mm_ones),
        .ss_tens  (ss_tens),
        .ss_ones  (ss_ones),
        .set_mode (set_mode),
        .day_wrap (day_wrap)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int wraps    = 0;
    bit checking = 0;

    // model state: time as hours/minutes/seconds integers, mode 0/1/2
    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_hold = 0;
    bit m_pm = 0, m_pi = 0, m_armed = 0, m_wrap = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    always @(posedge clk_in or negedge reset_) begin : model_blk
        bit me, ie, rep;
        int t;
        if (!reset_) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_hold = 0;
            m_pm = 0; m_pi = 0; m_armed = 0; m_wrap = 0;
        end else begin
            me  = m_armed && btn_mode && !m_pm;
            ie  = m_armed && btn_inc && !m_pi;
            rep = 0;
            m_wrap = 0;
            if (me) begin
                m_mode = (m_mode + 1) % 3;
                if (m_mode == 1) m_s = 0;
                m_hold = 0;
            end else begin
                if (m_mode != 0 && tick && btn_inc && REPEAT_DELAY > 0) begin
                    if (m_hold < REPEAT_DELAY) m_hold++;
                    else rep = 1;
                end
                if (!btn_inc) m_hold = 0;
                if (m_mode != 0) begin
                    if (ie || rep) begin
                        if (m_mode == 1) m_h = (m_h + 1) % (HOUR_MAX + 1);
                        else             m_m = (m_m + 1) % 60;
                    end
                end else if (tick) begin
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % ((HOUR_MAX + 1) * 3600);
                    m_wrap = (t == 0);
                    m_h = t / 3600;
                    m_m = (t / 60) % 60;
                    m_s = t % 60;
                end
            end
            m_pm = btn_mode;
            m_pi = btn_inc;
            m_armed = 1;
        end
    end

    always @(negedge clk_in) begin
        if (checking) begin
            chk("hh_tens", hh_tens, m_h / 10);
            chk("hh_ones", hh_ones, m_h % 10);
            chk("mm_tens", mm_tens, m_m / 10);
            chk("mm_ones", mm_ones, m_m % 10);
            chk("ss_tens", ss_tens, m_s / 10);
            chk("ss_ones", ss_ones, m_s % 10);
            chk("set_mode", set_mode, m_mode);
            chk("day_wrap", day_wrap, m_wrap);
            if (day_wrap) wraps++;
        end
    end

    task automatic check_time(input string nm, input int h, input int m, input int s, input int md);
        chk({nm, "_hh"}, hh_tens * 10 + hh_ones, h);
        chk({nm, "_mm"}, mm_tens * 10 + mm_ones, m);
        chk({nm, "_ss"}, ss_tens * 10 + ss_ones, s);
        chk({nm, "_mode"}, set_mode, md);
        chk({nm, "_model"}, m_h * 10000 + m_m * 100 + m_s, h * 10000 + m * 100 + s);
    endtask

    task automatic step(input bit t, input bit m, input bit i);
        tick = t;
        btn_mode = m;
        btn_inc = i;
        @(posedge clk_in);
        #2;
    endtask

    task automatic press_mode();
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
    endtask

    initial begin
        bit bm, bi, tk;
        #1 reset_ = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        check_time("reset", 0, 0, 0, 0);
        chk("reset_day_wrap", day_wrap, 0);
        reset_ = 1'b1;
        checking = 1;

        ticks(3661);
        check_time("run_3661", 1, 1, 1, 0);
        chk("no_wrap_yet", wraps, 0);

        press_mode();
        check_time("enter_set_hh", 1, 1, 0, 1);
        press_inc(22);
        press_mode();
        press_inc(58);
        press_mode();
        check_time("preload", 23, 59, 0, 0);
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 0);
            if (i != 59) step(0, 0, 0);
        end
        check_time("rollover", 0, 0, 0, 0);
        chk("rollover_wrap_hi", day_wrap, 1);
        step(0, 0, 0);
        chk("rollover_wrap_lo", day_wrap, 0);
        chk("wrap_count", wraps, 1);

        press_mode();
        press_inc(10);
        press_mode();
        press_inc(20);
        press_mode();
        ticks(35);
        check_time("at_102035", 10, 20, 35, 0);
        press_mode();
        check_time("set_hh_clear_ss", 10, 20, 0, 1);
        press_inc(14);
        check_time("hh_wrap_set", 0, 20, 0, 1);
        ticks(5);
        check_time("frozen_hh", 0, 20, 0, 1);
        press_mode();
        press_inc(45);
        check_time("mm_wrap_set", 0, 5, 0, 2);
        ticks(3);
        check_time("frozen_mm", 0, 5, 0, 2);
        press_mode();
        check_time("back_to_run", 0, 5, 0, 0);

        press_mode();
        press_mode();
        press_inc(53);
        step(0, 0, 1);
        check_time("rep_edge", 0, 59, 0, 2);
        begin
            int exp_mm[5] = '{59, 59, 0, 1, 2};
            for (int k = 0; k < 5; k++) begin
                step(1, 0, 1);
                check_time($sformatf("rep_tick%0d", k + 1), 0, exp_mm[k], 0, 2);
                step(0, 0, 1);
            end
        end
        step(0, 0, 0);
        press_mode();
        check_time("rep_done", 0, 2, 0, 0);

        press_mode();
        press_inc(12);
        press_mode();
        press_inc(58);
        press_mode();
        ticks(10);
        check_time("at_120010", 12, 0, 10, 0);
        step(1, 1, 0);
        check_time("tick_vs_mode", 12, 0, 0, 1);
        step(0, 0, 0);
        step(0, 1, 1);
        check_time("inc_vs_mode", 12, 0, 0, 2);
        step(0, 0, 0);

        press_mode();
        press_mode();
        press_inc(19);
        press_mode();
        press_inc(33);
        check_time("at_0733", 7, 33, 0, 2);
        #1;
        reset_ = 1'b0;
        btn_mode = 1'b1;
        #1;
        check_time("async_reset", 0, 0, 0, 0);
        chk("async_reset_wrap", day_wrap, 0);
        @(posedge clk_in);
        #3 reset_ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0);
            chk("held_mode_no_edge", set_mode, 0);
        end
        step(0, 0, 0);
        step(0, 1, 0);
        check_time("mode_after_toggle", 0, 0, 0, 1);
        step(0, 0, 0);

        bm = 0;
        bi = 0;
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 29) == 0) bm = ~bm;
            if ($urandom_range(0, 7) == 0) bi = ~bi;
            tk = ($urandom_range(0, 3) == 0);
            step(tk, bm, bi);
            if ($urandom_range(0, 1999) == 0) begin
                #1 reset_ = 1'b0;
                #3 reset_ = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
